// File: rtl/ofdm_frame_sequencer.sv
// Frame sequencer for the OFDM transmit path: preamble symbols from ROM, then data symbols
// from the IFFT buffer, each emitted as cyclic prefix followed by body, with downstream backpressure.
module ofdm_frame_sequencer #(
  parameter int NFFT   = 64,
  parameter int NCP    = 16,
  parameter int N_PRE  = 2,
  parameter int N_DATA = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  input  logic              ready_in,
  input  logic              sym_ready,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  output logic              sel_preamble,
  output logic              sym_done,
  output logic              valid_OFDM,
  output logic              sop,
  output logic              eof,
  output logic              busy
);

  localparam int                N_SYM    = N_PRE + N_DATA;
  localparam logic [ADDR_W-1:0] CP_START = ADDR_W'(NFFT - NCP);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NFFT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, CP, BODY} state_t;

  state_t     state;
  logic [8:0] sym_idx;

  logic in_sym;
  logic is_pre;
  logic last_sym;
  logic adv;
  logic first_cp;
  logic last_body;

  assign in_sym    = (state == CP) || (state == BODY);
  assign is_pre    = sym_idx < 9'(N_PRE);
  assign last_sym  = sym_idx == 9'(N_SYM - 1);
  assign adv       = enable & ready_in & in_sym;
  assign first_cp  = adv & (state == CP) & (rd_addr == CP_START);
  assign last_body = adv & (state == BODY) & (rd_addr == LAST_ADDR);

  assign rd_en        = adv;
  assign sel_preamble = in_sym & is_pre;
  assign sym_done     = last_body & ~is_pre;
  assign busy         = state != IDLE;

  // Output pipeline shares the enable gate with the FSM so a frozen cycle leaves no trace downstream.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sym_idx    <= '0;
      rd_addr    <= '0;
      valid_OFDM <= 1'b0;
      sop        <= 1'b0;
      eof        <= 1'b0;
    end else if (enable) begin
      valid_OFDM <= adv;
      sop        <= first_cp;
      eof        <= last_body & last_sym;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            sym_idx <= '0;
          end
        end
        LOAD: begin
          // Preamble comes from ROM and never waits; data symbols wait for a filled buffer.
          if (is_pre || sym_ready) begin
            state   <= CP;
            rd_addr <= CP_START;
          end
        end
        CP: begin
          if (ready_in) begin
            rd_addr <= rd_addr + ADDR_W'(1);
            if (rd_addr == LAST_ADDR) state <= BODY;
          end
        end
        BODY: begin
          if (ready_in) begin
            rd_addr <= rd_addr + ADDR_W'(1);
            if (rd_addr == LAST_ADDR) begin
              sym_idx <= sym_idx + 9'd1;
              state   <= last_sym ? IDLE : LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
